led_pwm_sched: RTL and testbench
================================

LED_PWM_SCHED -- requirements
Module: led_pwm_sched

Interface
REQ-001 SHALL have parameter NUM_RGB, default 4, meaning number of RGB LEDs; channel count NCH = 3*NUM_RGB.
REQ-002 SHALL have parameter PRESC_W, default 16, meaning prescaler width.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable_i, input, 1, run PWM when high.
REQ-006 SHALL have port prescale_i, input, PRESC_W, ticks per PWM step minus one.
REQ-007 SHALL have port cfg_we_i, input, 1, shadow duty write strobe.
REQ-008 SHALL have port cfg_addr_i, input, 4, channel index: ch = 3*led + {0:b,1:g,2:r}.
REQ-009 SHALL have port cfg_wdata_i, input, 8, duty value.
REQ-010 SHALL have port update_req_i, input, 1, request shadow-to-active copy.
REQ-011 SHALL have port update_pending_o, output, 1, copy requested but not yet done.
REQ-012 SHALL have port period_start_o, output, 1, one-cycle pulse at each PWM period start.
REQ-013 SHALL have port led_o, output, NCH, registered channel drive, bit ch = channel ch.

Function
REQ-014 SHALL keep a prescaler counter; tick asserted when it equals prescale_i, then it clears to 0; prescale_i=0 gives a tick every cycle.
REQ-015 SHALL keep an 8-bit step counter cnt, incremented on each tick, wrapping 255->0.
REQ-016 Boundary SHALL be the cycle with tick high and cnt=255; period_start_o SHALL pulse on the following cycle.
REQ-017 Per channel phase SHALL be (ch/3)*64 mod 256, staggering the RGB LEDs to spread current.
REQ-018 led_o[ch] SHALL be registered as ((cnt - phase) mod 256) < active_duty[ch]; 1-cycle latency from cnt.
REQ-019 Duty 0 SHALL give constant off; duty 255 SHALL give 255 of 256 steps on.
REQ-020 cfg_we_i SHALL write only shadow_duty[cfg_addr_i]; addresses >= NCH SHALL be ignored.
REQ-021 update_req_i SHALL set update_pending_o on the next cycle; while pending, active_duty SHALL copy shadow_duty at the boundary edge and pending SHALL clear.
REQ-022 A write in the boundary cycle SHALL update shadow only; the copy SHALL use the pre-write shadow value.
REQ-023 update_req_i in the boundary cycle SHALL be serviced at the next boundary, not the current one.
REQ-024 With enable_i low: prescaler and cnt held at 0, led_o all 0, period_start_o 0; a pending update SHALL copy on the next cycle.
REQ-025 enable_i rising SHALL start from cnt=0, prescaler 0; period_start_o SHALL pulse one cycle after the first enabled cycle.
REQ-026 prescale_i changes SHALL take effect at the next comparison; if the counter exceeds the new value it SHALL count to wrap at all-ones then clear.

Reset
REQ-027 rst SHALL asynchronously clear prescaler, cnt, all shadow and active duties, update_pending_o, period_start_o and led_o to 0.
REQ-028 Reset mid-period or with an update pending SHALL discard the pending update.

Structure
REQ-029 Shared package led_pwm_pkg SHALL hold the duty width constant (8), the phase step (64), and the colour-offset constants B=0, G=1, R=2.
REQ-030 A per-channel sub-module led_pwm_chan (phase subtract, compare, output register) SHALL be instantiated NCH times.

Verification
REQ-031 prescale_i=0, all duties 0x80, update -> each led_o bit high 128 of every 256 cycles; LED1 channels lag LED0 by 64 cycles.
REQ-032 Duty ch0=0, ch2=255 -> led_o[0] never high; led_o[2] low exactly 1 cycle per 256.
REQ-033 Write ch5=0x40 without update_req -> led_o[5] unchanged for 3 periods; then update_req -> change occurs exactly at the next period_start_o.
REQ-034 Write ch3 and assert update_req in the boundary cycle -> no copy at that boundary; new value active after the next one.
REQ-035 prescale_i=3 -> period_start_o every 1024 cycles; enable_i low mid-period -> led_o=0 next cycle, restart from cnt=0.
REQ-036 Assert rst with update pending mid-period -> all outputs 0 immediately, update_pending_o=0, duties 0 after release.

Source files
------------

// File: rtl/led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_pkg
// Description : Shared constants for the staggered RGB LED PWM scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pwm_pkg;

    // Duty and step counter width
    localparam int DUTY_W     = 8;
    // Phase offset between consecutive RGB LEDs, in PWM steps
    localparam int PHASE_STEP = 64;

    // Colour offsets within one LED: ch = 3*led + colour
    localparam int COL_B = 0;
    localparam int COL_G = 1;
    localparam int COL_R = 2;

    // Phase of a channel: all three colours of one LED share the LED's phase
    function automatic logic [DUTY_W-1:0] chan_phase(input int ch);
        return DUTY_W'(((ch / 3) * PHASE_STEP) % 256);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_chan.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_chan
// Description : One PWM channel: phase-shifted step compare with registered
//               output drive.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter logic [DUTY_W-1:0] PHASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty,
    output logic              led
);

    // Step position within this channel's own (shifted) period, modulo 256
    logic [DUTY_W-1:0] rel_step;
    assign rel_step = cnt - PHASE;

    // Output register: on while the shifted step is below the duty value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= enable && (rel_step < duty);
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pwm_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_sched
// Description : Multi-channel RGB LED PWM with prescaler, phase staggering
//               between LEDs and glitch-free shadow-to-active duty updates.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_sched
    import led_pwm_pkg::*;
#(
    parameter int NUM_RGB = 4,
    parameter int PRESC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [PRESC_W-1:0]   prescale_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_addr_i,
    input  logic [DUTY_W-1:0]    cfg_wdata_i,
    input  logic                 update_req_i,
    output logic                 update_pending_o,
    output logic                 period_start_o,
    output logic [3*NUM_RGB-1:0] led_o
);

    localparam int NCH = 3 * NUM_RGB;

    logic [PRESC_W-1:0] presc;
    logic [DUTY_W-1:0]  cnt;
    logic               enable_d;
    logic               tick;
    logic               boundary;
    logic               copy;
    logic [DUTY_W-1:0]  shadow_duty [NCH];
    logic [DUTY_W-1:0]  active_duty [NCH];

    // A pending copy happens at the period boundary, or immediately when idle
    assign tick     = enable_i && (presc == prescale_i);
    assign boundary = tick && (cnt == {DUTY_W{1'b1}});
    assign copy     = update_pending_o && (boundary || !enable_i);

    // Prescaler and step counter; both held at zero while disabled.
    // A counter above a newly lowered prescale runs on to wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            cnt   <= '0;
        end else if (!enable_i) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Period start pulse: after each boundary and after the first enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_d       <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            enable_d       <= enable_i;
            period_start_o <= boundary || (enable_i && !enable_d);
        end
    end

    // Update request tracking; a request in the copy cycle waits for the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_pending_o <= 1'b0;
        end else begin
            update_pending_o <= update_req_i || (update_pending_o && !copy);
        end
    end

    // Shadow writes and shadow-to-active copy (copy sees the pre-write shadow)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                shadow_duty[ch] <= '0;
                active_duty[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (cfg_we_i && (int'(cfg_addr_i) == ch)) begin
                    shadow_duty[ch] <= cfg_wdata_i;
                end
                if (copy) begin
                    active_duty[ch] <= shadow_duty[ch];
                end
            end
        end
    end

    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
            led_pwm_chan #(
                .PHASE (chan_phase(ch))
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .enable (enable_i),
                .cnt    (cnt),
                .duty   (active_duty[ch]),
                .led    (led_o[ch])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_sched
// Description : Self-checking bench for led_pwm_sched: cycle model compared
//               every cycle plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_sched;

    localparam int NUM_RGB = 4;
    localparam int PRESC_W = 16;
    localparam int NCH     = 3 * NUM_RGB;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable_i = 1'b0;
    logic [PRESC_W-1:0] prescale_i = '0;
    logic               cfg_we_i = 1'b0;
    logic [3:0]         cfg_addr_i = '0;
    logic [7:0]         cfg_wdata_i = '0;
    logic               update_req_i = 1'b0;
    logic               update_pending_o;
    logic               period_start_o;
    logic [NCH-1:0]     led_o;

    int checks = 0;
    int errors = 0;

    led_pwm_sched #(
        .NUM_RGB (NUM_RGB),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable_i),
        .prescale_i       (prescale_i),
        .cfg_we_i         (cfg_we_i),
        .cfg_addr_i       (cfg_addr_i),
        .cfg_wdata_i      (cfg_wdata_i),
        .update_req_i     (update_req_i),
        .update_pending_o (update_pending_o),
        .period_start_o   (period_start_o),
        .led_o            (led_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (integer arithmetic) ----------------
    int             m_presc, m_cnt;
    bit             m_en_prev, m_pending, m_ps;
    int             m_shadow [NCH];
    int             m_active [NCH];
    logic [NCH-1:0] m_led;

    always @(posedge clk or posedge rst) begin
        bit m_tick, m_bnd, m_copy;
        if (rst) begin
            m_presc = 0; m_cnt = 0; m_en_prev = 0; m_pending = 0; m_ps = 0;
            m_led = '0;
            for (int c = 0; c < NCH; c++) begin
                m_shadow[c] = 0;
                m_active[c] = 0;
            end
        end else begin
            // Output for the step that was current during this cycle
            for (int c = 0; c < NCH; c++)
                m_led[c] = enable_i && ((((m_cnt - 64 * (c / 3)) % 256 + 256) % 256) < m_active[c]);
            m_tick = enable_i && (m_presc == int'(prescale_i));
            m_bnd  = m_tick && (m_cnt == 255);
            m_ps   = m_bnd || (enable_i && !m_en_prev);
            m_copy = m_pending && (m_bnd || !enable_i);
            if (m_copy)
                for (int c = 0; c < NCH; c++) m_active[c] = m_shadow[c];
            m_pending = update_req_i || (m_pending && !m_copy);
            if (cfg_we_i && int'(cfg_addr_i) < NCH)
                m_shadow[cfg_addr_i] = int'(cfg_wdata_i);
            if (!enable_i) begin
                m_presc = 0; m_cnt = 0;
            end else if (m_tick) begin
                m_presc = 0; m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_presc = (m_presc + 1) % (1 << PRESC_W);
            end
            m_en_prev = enable_i;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("model_led", led_o, m_led);
        chk("model_period_start", period_start_o, m_ps);
        chk("model_pending", update_pending_o, m_pending);
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wr(input int addr, input int data);
        cfg_we_i = 1'b1; cfg_addr_i = 4'(addr); cfg_wdata_i = 8'(data);
        @(negedge clk);
        cfg_we_i = 1'b0;
    endtask

    task automatic upd();
        update_req_i = 1'b1;
        @(negedge clk);
        update_req_i = 1'b0;
    endtask

    task automatic wait_ps(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start_o && n < max);
        chk("period_start_arrives", period_start_o, 1);
    endtask

    // Samples len cycles; counts highs and first high index (1-based) of two channels
    task automatic win2(input int a, input int b, input int len,
                        output int ha, output int hb, output int fa, output int fb);
        ha = 0; hb = 0; fa = -1; fb = -1;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (led_o[a]) begin ha++; if (fa < 0) fa = i; end
            if (led_o[b]) begin hb++; if (fb < 0) fb = i; end
        end
    endtask

    initial begin
        int n, ha, hb, fa, fb, any_hi;

        // Reset state
        @(negedge clk);
        chk("reset_led", led_o, 0);
        chk("reset_pending", update_pending_o, 0);
        chk("reset_ps", period_start_o, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // All duties 0x80, update while idle: copies on the following cycle
        for (int c = 0; c < NCH; c++) wr(c, 8'h80);
        wr(15, 8'hFF);                       // out of range: ignored
        upd();
        chk("pending_set", update_pending_o, 1);
        @(negedge clk);
        chk("pending_idle_copy", update_pending_o, 0);

        enable_i = 1'b1;
        wait_ps(5, n);
        chk("start_pulse_latency", n, 1);
        wait_ps(300, n);
        win2(0, 3, 256, ha, hb, fa, fb);
        chk("half_duty_led0", ha, 128);
        chk("half_duty_led3", hb, 128);
        chk("led1_lag", fb - fa, 64);
        chk("ps_after_256", period_start_o, 1);

        // Duty 0 and 255 extremes
        wr(0, 0);
        wr(2, 255);
        upd();
        wait_ps(300, n);
        win2(0, 2, 256, ha, hb, fa, fb);
        chk("duty0_never_on", ha, 0);
        chk("duty255_off_steps", 256 - hb, 1);

        // Shadow write without update leaves output untouched
        wr(5, 8'h40);
        wait_ps(300, n);
        for (int p = 0; p < 3; p++) begin
            win2(5, 4, 256, ha, hb, fa, fb);
            chk("ch5_unchanged", ha, 128);
        end
        upd();
        wait_ps(300, n);
        win2(5, 4, 256, ha, hb, fa, fb);
        chk("ch5_updated", ha, 64);

        // Write and request in the boundary cycle: serviced one period later
        repeat (255) @(negedge clk);
        cfg_we_i = 1'b1; cfg_addr_i = 4'd3; cfg_wdata_i = 8'h10; update_req_i = 1'b1;
        @(negedge clk);
        cfg_we_i = 1'b0; update_req_i = 1'b0;
        chk("bnd_ps", period_start_o, 1);
        chk("bnd_still_pending", update_pending_o, 1);
        win2(3, 0, 256, ha, hb, fa, fb);
        chk("bnd_ch3_old", ha, 128);
        chk("bnd_pending_cleared", update_pending_o, 0);
        win2(3, 0, 256, ha, hb, fa, fb);
        chk("bnd_ch3_new", ha, 16);

        // Prescale 3: four cycles per step
        prescale_i = 16'd3;
        wait_ps(2000, n);
        wait_ps(2000, n);
        chk("presc3_period", n, 1024);

        // Disable mid-period, then restart from step 0
        repeat (100) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        chk("disable_led", led_o, 0);
        chk("disable_ps", period_start_o, 0);
        repeat (5) @(negedge clk);
        enable_i = 1'b1;
        @(negedge clk);
        chk("restart_pulse", period_start_o, 1);
        // First enabled cycle belongs to the period, so the next start is 1023 later
        wait_ps(2000, n);
        chk("restart_first_period", n, 1023);

        // Reset with an update pending mid-period
        prescale_i = 16'd0;
        repeat (40) @(negedge clk);
        wr(1, 8'h33);
        upd();
        chk("pre_rst_pending", update_pending_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_led_immediate", led_o, 0);
        chk("rst_pending_immediate", update_pending_o, 0);
        chk("rst_ps_immediate", period_start_o, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        any_hi = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (led_o != '0) any_hi++;
        end
        chk("post_rst_duties_zero", any_hi, 0);
        chk("post_rst_pending", update_pending_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
